// File: rtl/sy_axi_mux.sv
// N-to-1 AXI4 multiplexer: round-robin AW/AR arbitration with grant lock,
// W routing through an index FIFO, and B/R routing by the prepended ID bits.
package sy_axi;
  localparam int unsigned IdWidth    = 4;
  localparam int unsigned SlvIdWidth = 5;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
  } ax_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [31:0]           addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_slv_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_slv_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        data;
    logic [1:0]         resp;
    logic               last;
  } r_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [31:0]           data;
    logic [1:0]            resp;
    logic                  last;
  } r_slv_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    r_t   r;
    logic r_valid;
  } resp_t;

  typedef struct packed {
    ax_slv_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    ax_slv_t ar;
    logic    ar_valid;
    logic    r_ready;
  } req_slv_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    b_slv_t b;
    logic   b_valid;
    r_slv_t r;
    logic   r_valid;
  } resp_slv_t;
endpackage

module sy_axi_mux #(
  parameter int unsigned NrMasters = 2,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxWTrans = 4,
  parameter type slv_req_t  = sy_axi::req_t,
  parameter type slv_resp_t = sy_axi::resp_t,
  parameter type mst_req_t  = sy_axi::req_slv_t,
  parameter type mst_resp_t = sy_axi::resp_slv_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_reqs_i [NrMasters],
  output slv_resp_t slv_resps_o [NrMasters],
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);
  localparam int unsigned IdxW       = $clog2(NrMasters);
  localparam int unsigned MstIdWidth = IdWidth + IdxW;
  localparam int unsigned PtrW       = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned CntW       = $clog2(MaxWTrans + 1);
  localparam bit          Pow2       = (NrMasters == (1 << IdxW));

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  // First requester at or after start, wrapping; returns start when none.
  function automatic idx_t rr_pick(input logic [NrMasters-1:0] req, input idx_t start);
    idx_t        res;
    logic        found;
    int unsigned cand;
    res   = start;
    found = 1'b0;
    for (int unsigned o = 0; o < NrMasters; o++) begin
      cand = (32'(start) + o) % NrMasters;
      if (!found && req[cand]) begin
        found = 1'b1;
        res   = idx_t'(cand);
      end
    end
    return res;
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(NrMasters - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxWTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [NrMasters-1:0] aw_req, ar_req;
  for (genvar gi = 0; gi < NrMasters; gi++) begin : g_req
    assign aw_req[gi] = slv_reqs_i[gi].aw_valid;
    assign ar_req[gi] = slv_reqs_i[gi].ar_valid;
  end

  idx_t aw_prio_reg, aw_lock_idx_reg, ar_prio_reg, ar_lock_idx_reg;
  logic aw_lock_reg, ar_lock_reg;
  idx_t fifo_mem [MaxWTrans];
  ptr_t wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0] fifo_cnt_reg;

  idx_t aw_sel, ar_sel, w_head, b_idx, r_idx;
  logic fifo_full, fifo_empty;
  logic aw_go, ar_go, aw_hs, ar_hs, w_pop;
  logic b_route_ok, r_route_ok;

  // A locked grant holds the selection until the downstream handshake.
  assign aw_sel     = aw_lock_reg ? aw_lock_idx_reg : rr_pick(aw_req, aw_prio_reg);
  assign ar_sel     = ar_lock_reg ? ar_lock_idx_reg : rr_pick(ar_req, ar_prio_reg);
  assign fifo_full  = (fifo_cnt_reg == CntW'(MaxWTrans));
  assign fifo_empty = (fifo_cnt_reg == '0);
  assign w_head     = fifo_mem[rd_ptr_reg];

  assign aw_go = rst_ni && !fifo_full && slv_reqs_i[aw_sel].aw_valid;
  assign ar_go = rst_ni && slv_reqs_i[ar_sel].ar_valid;
  assign aw_hs = aw_go && mst_resp_i.aw_ready;
  assign ar_hs = ar_go && mst_resp_i.ar_ready;
  assign w_pop = rst_ni && !fifo_empty && slv_reqs_i[w_head].w_valid
                 && slv_reqs_i[w_head].w.last && mst_resp_i.w_ready;

  assign b_idx      = mst_resp_i.b.id[MstIdWidth-1 -: IdxW];
  assign r_idx      = mst_resp_i.r.id[MstIdWidth-1 -: IdxW];
  assign b_route_ok = Pow2 || (32'(b_idx) < NrMasters);
  assign r_route_ok = Pow2 || (32'(r_idx) < NrMasters);

  always_comb begin
    mst_req_o = '0;
    for (int i = 0; i < NrMasters; i++) slv_resps_o[i] = '0;
    if (rst_ni) begin
      mst_req_o.aw.id    = {aw_sel, slv_reqs_i[aw_sel].aw.id};
      mst_req_o.aw.addr  = slv_reqs_i[aw_sel].aw.addr;
      mst_req_o.aw.len   = slv_reqs_i[aw_sel].aw.len;
      mst_req_o.aw.size  = slv_reqs_i[aw_sel].aw.size;
      mst_req_o.aw.burst = slv_reqs_i[aw_sel].aw.burst;
      mst_req_o.aw_valid = aw_go;
      mst_req_o.ar.id    = {ar_sel, slv_reqs_i[ar_sel].ar.id};
      mst_req_o.ar.addr  = slv_reqs_i[ar_sel].ar.addr;
      mst_req_o.ar.len   = slv_reqs_i[ar_sel].ar.len;
      mst_req_o.ar.size  = slv_reqs_i[ar_sel].ar.size;
      mst_req_o.ar.burst = slv_reqs_i[ar_sel].ar.burst;
      mst_req_o.ar_valid = ar_go;
      if (!fifo_empty) begin
        mst_req_o.w       = slv_reqs_i[w_head].w;
        mst_req_o.w_valid = slv_reqs_i[w_head].w_valid;
      end
      // Unroutable response indices are swallowed so the bus cannot stall.
      mst_req_o.b_ready = b_route_ok ? slv_reqs_i[b_idx].b_ready : 1'b1;
      mst_req_o.r_ready = r_route_ok ? slv_reqs_i[r_idx].r_ready : 1'b1;
      for (int i = 0; i < NrMasters; i++) begin
        slv_resps_o[i].aw_ready = aw_go && (aw_sel == idx_t'(i)) && mst_resp_i.aw_ready;
        slv_resps_o[i].ar_ready = ar_go && (ar_sel == idx_t'(i)) && mst_resp_i.ar_ready;
        slv_resps_o[i].w_ready  = !fifo_empty && (w_head == idx_t'(i)) && mst_resp_i.w_ready;
        slv_resps_o[i].b.id     = mst_resp_i.b.id[IdWidth-1:0];
        slv_resps_o[i].b.resp   = mst_resp_i.b.resp;
        slv_resps_o[i].b_valid  = mst_resp_i.b_valid && (b_idx == idx_t'(i));
        slv_resps_o[i].r.id     = mst_resp_i.r.id[IdWidth-1:0];
        slv_resps_o[i].r.data   = mst_resp_i.r.data;
        slv_resps_o[i].r.resp   = mst_resp_i.r.resp;
        slv_resps_o[i].r.last   = mst_resp_i.r.last;
        slv_resps_o[i].r_valid  = mst_resp_i.r_valid && (r_idx == idx_t'(i));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_prio_reg     <= '0;
      aw_lock_reg     <= 1'b0;
      aw_lock_idx_reg <= '0;
      ar_prio_reg     <= '0;
      ar_lock_reg     <= 1'b0;
      ar_lock_idx_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_cnt_reg    <= '0;
    end else begin
      if (aw_hs) begin
        aw_lock_reg <= 1'b0;
        aw_prio_reg <= idx_inc(aw_sel);
      end else if (aw_go) begin
        aw_lock_reg     <= 1'b1;
        aw_lock_idx_reg <= aw_sel;
      end
      if (ar_hs) begin
        ar_lock_reg <= 1'b0;
        ar_prio_reg <= idx_inc(ar_sel);
      end else if (ar_go) begin
        ar_lock_reg     <= 1'b1;
        ar_lock_idx_reg <= ar_sel;
      end
      if (aw_hs) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (w_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (aw_hs && !w_pop) fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
      else if (w_pop && !aw_hs) fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) fifo_mem[wr_ptr_reg] <= aw_sel;
  end
endmodule

// File: tb/tb_sy_axi_mux.sv
// Bench for sy_axi_mux (4 ports, 2-deep W route): directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_sy_axi_mux;
  localparam int N = 4, IW = 4, MW = 2, MIW = 6;

  typedef struct packed {
    logic [MIW-1:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
  } max_t;
  typedef struct packed { logic [MIW-1:0] id; logic [1:0] resp; } mb_t;
  typedef struct packed { logic [MIW-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } mr_t;
  typedef struct packed {
    max_t aw; logic aw_valid; sy_axi::w_t w; logic w_valid; logic b_ready;
    max_t ar; logic ar_valid; logic r_ready;
  } mreq_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; mb_t b; logic b_valid; mr_t r; logic r_valid;
  } mresp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sy_axi::req_t  slv_reqs  [N];
  sy_axi::resp_t slv_resps [N];
  mreq_t  mst_req;
  mresp_t mst_resp;

  sy_axi_mux #(
    .NrMasters(N), .IdWidth(IW), .MaxWTrans(MW),
    .slv_req_t(sy_axi::req_t), .slv_resp_t(sy_axi::resp_t),
    .mst_req_t(mreq_t), .mst_resp_t(mresp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_reqs_i(slv_reqs), .slv_resps_o(slv_resps),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int   aw_ptr_m, ar_ptr_m, aw_lock_idx_m, ar_lock_idx_m;
  bit   aw_lock_m, ar_lock_m;
  int   wq[$];
  bit   aw_hs_p [N];
  bit   ar_hs_p [N];
  bit   w_hs_p  [N];
  logic any_o;
  logic [31:0] exp_w [5];

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int o = 0; o < N; o++) if (v[(start + o) % N]) return (start + o) % N;
    return -1;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) slv_reqs[i] = '0;
    mst_resp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    aw_ptr_m = 0; ar_ptr_m = 0; aw_lock_m = 0; ar_lock_m = 0;
    aw_lock_idx_m = 0; ar_lock_idx_m = 0;
    wq.delete();
    for (int i = 0; i < N; i++) begin aw_hs_p[i] = 0; ar_hs_p[i] = 0; w_hs_p[i] = 0; end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle of randomized traffic: check all outputs against the model, then advance it.
  task automatic random_cycle();
    logic [N-1:0] awv, arv;
    int  aw_c, ar_c, h, j;
    bit  full, exp_awv, exp_arv, aw_hs, ar_hs, w_pop;
    for (int i = 0; i < N; i++) begin
      if (aw_hs_p[i]) slv_reqs[i].aw_valid = 1'b0;
      if (ar_hs_p[i]) slv_reqs[i].ar_valid = 1'b0;
      if (w_hs_p[i])  slv_reqs[i].w_valid  = 1'b0;
      if (!slv_reqs[i].aw_valid && $urandom_range(0, 2) == 0) begin
        slv_reqs[i].aw_valid = 1'b1; slv_reqs[i].aw.id = 4'($urandom);
        slv_reqs[i].aw.addr = $urandom; slv_reqs[i].aw.len = 8'($urandom_range(0, 3));
      end
      if (!slv_reqs[i].ar_valid && $urandom_range(0, 2) == 0) begin
        slv_reqs[i].ar_valid = 1'b1; slv_reqs[i].ar.id = 4'($urandom);
        slv_reqs[i].ar.addr = $urandom;
      end
      if (!slv_reqs[i].w_valid && $urandom_range(0, 1) == 0) begin
        slv_reqs[i].w_valid = 1'b1; slv_reqs[i].w.data = $urandom;
        slv_reqs[i].w.last = ($urandom_range(0, 2) == 0);
      end
      slv_reqs[i].b_ready = 1'($urandom);
      slv_reqs[i].r_ready = 1'($urandom);
    end
    mst_resp.aw_ready = 1'($urandom); mst_resp.ar_ready = 1'($urandom);
    mst_resp.w_ready  = ($urandom_range(0, 3) != 0);
    mst_resp.b_valid  = 1'($urandom); mst_resp.b.id = 6'($urandom); mst_resp.b.resp = 2'($urandom);
    mst_resp.r_valid  = 1'($urandom); mst_resp.r.id = 6'($urandom); mst_resp.r.data = $urandom;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin awv[i] = slv_reqs[i].aw_valid; arv[i] = slv_reqs[i].ar_valid; end
    full    = (wq.size() == MW);
    aw_c    = aw_lock_m ? aw_lock_idx_m : pick(awv, aw_ptr_m);
    ar_c    = ar_lock_m ? ar_lock_idx_m : pick(arv, ar_ptr_m);
    exp_awv = !full && aw_c >= 0 && awv[aw_c];
    exp_arv = ar_c >= 0 && arv[ar_c];
    check_value("rnd aw_valid", mst_req.aw_valid, exp_awv);
    check_value("rnd ar_valid", mst_req.ar_valid, exp_arv);
    if (exp_awv) begin
      check_value("rnd aw.id", mst_req.aw.id, {2'(aw_c), slv_reqs[aw_c].aw.id});
      check_value("rnd aw.addr", mst_req.aw.addr, slv_reqs[aw_c].aw.addr);
    end
    if (exp_arv) check_value("rnd ar.id", mst_req.ar.id, {2'(ar_c), slv_reqs[ar_c].ar.id});
    h = (wq.size() > 0) ? wq[0] : -1;
    check_value("rnd w_valid", mst_req.w_valid, (h >= 0) ? slv_reqs[h].w_valid : 1'b0);
    if (h >= 0 && slv_reqs[h].w_valid) check_value("rnd w.data", mst_req.w.data, slv_reqs[h].w.data);
    j = int'(mst_resp.b.id[5:4]);
    check_value("rnd b_ready", mst_req.b_ready, slv_reqs[j].b_ready);
    j = int'(mst_resp.r.id[5:4]);
    check_value("rnd r_ready", mst_req.r_ready, slv_reqs[j].r_ready);
    for (int i = 0; i < N; i++) begin
      aw_hs_p[i] = exp_awv && i == aw_c && mst_resp.aw_ready;
      ar_hs_p[i] = exp_arv && i == ar_c && mst_resp.ar_ready;
      w_hs_p[i]  = (i == h) && mst_resp.w_ready && slv_reqs[i].w_valid;
      check_value("rnd aw_ready", slv_resps[i].aw_ready, aw_hs_p[i]);
      check_value("rnd ar_ready", slv_resps[i].ar_ready, ar_hs_p[i]);
      check_value("rnd w_ready", slv_resps[i].w_ready, (i == h) && mst_resp.w_ready);
      check_value("rnd b_valid", slv_resps[i].b_valid, mst_resp.b_valid && (i == int'(mst_resp.b.id[5:4])));
      check_value("rnd b.id", slv_resps[i].b.id, mst_resp.b.id[3:0]);
      check_value("rnd r_valid", slv_resps[i].r_valid, mst_resp.r_valid && (i == int'(mst_resp.r.id[5:4])));
      check_value("rnd r.data", slv_resps[i].r.data, mst_resp.r.data);
    end
    aw_hs = exp_awv && mst_resp.aw_ready;
    ar_hs = exp_arv && mst_resp.ar_ready;
    w_pop = h >= 0 && slv_reqs[h].w_valid && slv_reqs[h].w.last && mst_resp.w_ready;
    if (aw_hs) $display("AW port %0d id %0h len %0d", aw_c, mst_req.aw.id, mst_req.aw.len);
    if (ar_hs) $display("AR port %0d id %0h", ar_c, mst_req.ar.id);
    if (w_pop) void'(wq.pop_front());
    if (aw_hs) begin wq.push_back(aw_c); aw_ptr_m = (aw_c + 1) % N; aw_lock_m = 0; end
    else if (exp_awv) begin aw_lock_m = 1; aw_lock_idx_m = aw_c; end
    if (ar_hs) begin ar_ptr_m = (ar_c + 1) % N; ar_lock_m = 0; end
    else if (exp_arv) begin ar_lock_m = 1; ar_lock_idx_m = ar_c; end
    next_cycle();
  endtask

  initial begin
    // Reset hold with every upstream and downstream valid asserted
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      slv_reqs[i].aw_valid = 1'b1; slv_reqs[i].aw.id = 4'(i);
      slv_reqs[i].ar_valid = 1'b1; slv_reqs[i].w_valid = 1'b1; slv_reqs[i].w.last = 1'b1;
      slv_reqs[i].b_ready = 1'b1; slv_reqs[i].r_ready = 1'b1;
    end
    mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 6'h10; mst_resp.r_valid = 1'b1; mst_resp.r.id = 6'h20;
    repeat (3) begin
      @(negedge clk);
      check_value("rst aw_valid", mst_req.aw_valid, 1'b0);
      check_value("rst ar_valid", mst_req.ar_valid, 1'b0);
      check_value("rst w_valid", mst_req.w_valid, 1'b0);
      check_value("rst b_ready", mst_req.b_ready, 1'b0);
      check_value("rst r_ready", mst_req.r_ready, 1'b0);
      any_o = 1'b0;
      for (int i = 0; i < N; i++)
        any_o = any_o | slv_resps[i].aw_ready | slv_resps[i].ar_ready | slv_resps[i].w_ready
                | slv_resps[i].b_valid | slv_resps[i].r_valid;
      check_value("rst upstream", any_o, 1'b0);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_value("post-rst aw_valid", mst_req.aw_valid, 1'b1);
    check_value("post-rst aw.id", mst_req.aw.id, 6'h00);
    $display("Reset hold: first AW grant id %0h", mst_req.aw.id);

    // AR round robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) begin slv_reqs[i].ar_valid = 1'b1; slv_reqs[i].ar.id = 4'(i + 5); end
    mst_resp.ar_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value("rr ar.id", mst_req.ar.id, {2'(k % N), 4'(k % N + 5)});
      check_value("rr ar_ready", slv_resps[k % N].ar_ready, 1'b1);
      $display("AR grant %0d id %0h", k % N, mst_req.ar.id);
      next_cycle();
    end

    // AW grant stays on port 1 while port 0 arrives mid-handshake
    do_reset();
    slv_reqs[1].aw_valid = 1'b1; slv_reqs[1].aw.id = 4'h3;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin slv_reqs[0].aw_valid = 1'b1; slv_reqs[0].aw.id = 4'h7; end
      @(negedge clk);
      check_value("lock aw_valid", mst_req.aw_valid, 1'b1);
      check_value("lock aw.id", mst_req.aw.id, 6'h13);
      next_cycle();
    end
    mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    check_value("lock hs p1", slv_resps[1].aw_ready, 1'b1);
    check_value("lock hs p0", slv_resps[0].aw_ready, 1'b0);
    next_cycle();
    slv_reqs[1].aw_valid = 1'b0;
    @(negedge clk);
    check_value("lock next id", mst_req.aw.id, 6'h07);
    $display("AW lock: port 1 then port 0 id %0h", mst_req.aw.id);

    // W ordering: port 2 burst of 4 precedes port 0 single beat
    do_reset();
    exp_w[0] = 32'hA0; exp_w[1] = 32'hA1; exp_w[2] = 32'hA2; exp_w[3] = 32'hA3; exp_w[4] = 32'hE0;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    slv_reqs[2].aw_valid = 1'b1; slv_reqs[2].aw.id = 4'h1; slv_reqs[2].aw.len = 8'd3;
    slv_reqs[2].w_valid = 1'b1; slv_reqs[2].w.data = 32'hA0;
    slv_reqs[0].w_valid = 1'b1; slv_reqs[0].w.data = 32'hE0; slv_reqs[0].w.last = 1'b1;
    @(negedge clk);
    check_value("word aw.id p2", mst_req.aw.id, 6'h21);
    check_value("word no bypass", mst_req.w_valid, 1'b0);
    check_value("word p2 w_ready early", slv_resps[2].w_ready, 1'b0);
    next_cycle();
    slv_reqs[2].aw_valid = 1'b0;
    slv_reqs[0].aw_valid = 1'b1; slv_reqs[0].aw.id = 4'h2;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      check_value("word w_valid", mst_req.w_valid, 1'b1);
      check_value("word w.data", mst_req.w.data, exp_w[b]);
      check_value("word p0 w_ready", slv_resps[0].w_ready, b == 4);
      check_value("word p2 w_ready", slv_resps[2].w_ready, b < 4);
      $display("W beat %0d data %0h", b, mst_req.w.data);
      next_cycle();
      if (b == 0) slv_reqs[0].aw_valid = 1'b0;
      if (b < 3) begin slv_reqs[2].w.data = 32'hA1 + 32'(b); slv_reqs[2].w.last = (b == 2); end
      else if (b == 3) slv_reqs[2].w_valid = 1'b0;
      else slv_reqs[0].w_valid = 1'b0;
    end
    @(negedge clk);
    check_value("word drained", mst_req.w_valid, 1'b0);

    // W-route FIFO full stalls AW until a burst completes
    do_reset();
    mst_resp.aw_ready = 1'b1;
    slv_reqs[0].aw_valid = 1'b1; slv_reqs[0].aw.id = 4'h1;
    @(negedge clk);
    check_value("full aw0", mst_req.aw_valid, 1'b1);
    next_cycle();
    slv_reqs[0].aw_valid = 1'b0; slv_reqs[1].aw_valid = 1'b1; slv_reqs[1].aw.id = 4'h2;
    @(negedge clk);
    check_value("full aw1", mst_req.aw_valid, 1'b1);
    next_cycle();
    slv_reqs[1].aw_valid = 1'b0; slv_reqs[2].aw_valid = 1'b1; slv_reqs[2].aw.id = 4'h3;
    @(negedge clk);
    check_value("full stall", mst_req.aw_valid, 1'b0);
    check_value("full p2 ready", slv_resps[2].aw_ready, 1'b0);
    next_cycle();
    slv_reqs[0].w_valid = 1'b1; slv_reqs[0].w.last = 1'b1; mst_resp.w_ready = 1'b1;
    @(negedge clk);
    check_value("full pop cycle", mst_req.aw_valid, 1'b0);
    check_value("full p0 w_ready", slv_resps[0].w_ready, 1'b1);
    next_cycle();
    slv_reqs[0].w_valid = 1'b0;
    @(negedge clk);
    check_value("full reenabled", mst_req.aw_valid, 1'b1);
    check_value("full reenabled id", mst_req.aw.id, 6'h23);
    $display("FIFO full: AW re-enabled id %0h", mst_req.aw.id);

    // B/R routing by upper ID bits
    do_reset();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = {2'd1, 4'hA}; mst_resp.b.resp = 2'b10;
    mst_resp.r_valid = 1'b1; mst_resp.r.id = {2'd3, 4'h5}; mst_resp.r.data = 32'hCAFE0001;
    slv_reqs[0].b_ready = 1'b1; slv_reqs[1].b_ready = 1'b0; slv_reqs[3].r_ready = 1'b1;
    @(negedge clk);
    check_value("b p1 valid", slv_resps[1].b_valid, 1'b1);
    check_value("b p1 id", slv_resps[1].b.id, 4'hA);
    check_value("b p1 resp", slv_resps[1].b.resp, 2'b10);
    check_value("b p0 valid", slv_resps[0].b_valid, 1'b0);
    check_value("b ready lo", mst_req.b_ready, 1'b0);
    check_value("r p3 valid", slv_resps[3].r_valid, 1'b1);
    check_value("r p3 data", slv_resps[3].r.data, 32'hCAFE0001);
    check_value("r p2 valid", slv_resps[2].r_valid, 1'b0);
    check_value("r ready", mst_req.r_ready, 1'b1);
    slv_reqs[1].b_ready = 1'b1; slv_reqs[0].b_ready = 1'b0;
    #1;
    check_value("b ready hi", mst_req.b_ready, 1'b1);
    $display("B routed to port 1 id %0h", slv_resps[1].b.id);

    // Randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) random_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
